// File: rtl/apb_master_bridge.sv
// APB requester bridge: valid/ready command port to APB SETUP/ACCESS transfers on two slaves.
// Latency: accept at edge N, rsp_valid at N+2 for a zero-wait slave, +1 per slave wait cycle.
// Backpressure: cmd_ready is high only in IDLE; one transfer outstanding. Optional ACCESS
// timeout abort is compiled in with the APB_TIMEOUT_EN macro.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_BIT        = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              pwrite_q,    pwrite_d;
  logic              psel1_q,     psel1_d;
  logic              psel2_q,     psel2_d;
  logic              penable_q,   penable_d;

  // The latched address picks the slave; the other slave's PREADY/PRDATA are never looked at.
  logic              sel2;
  logic              pready_sel;
  logic [DATA_W-1:0] prdata_sel;
  logic              accept;
  logic              timeout_hit;

  assign sel2       = paddr_q[SEL_BIT];
  assign pready_sel = sel2 ? PREADY2 : PREADY1;
  assign prdata_sel = sel2 ? PRDATA2 : PRDATA1;
  assign accept     = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count ACCESS cycles spent waiting on the slave; restart for every new transfer.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_SETUP) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !pready_sel) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  // Abort on the edge where the wait count would reach the limit.
  assign timeout_hit = (state_q == ST_ACCESS) && !pready_sel &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the timeout the ACCESS phase waits on PREADY indefinitely.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // State and registered-output flops, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
    end
  end

  // Next-state: IDLE -> SETUP on accept, SETUP lasts one cycle, ACCESS until ready or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready_sel || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle; every port is driven straight from a flop.
  always_comb begin
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel1_d     = 1'b0;
    psel2_d     = 1'b0;
    penable_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          psel1_d  = !cmd_addr[SEL_BIT];
          psel2_d  = cmd_addr[SEL_BIT];
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready_sel) begin
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b1;
          if (!pwrite_q) rsp_rdata_d = prdata_sel;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          cmd_ready_d = 1'b1;
        end else begin
          psel1_d   = psel1_q;
          psel2_d   = psel2_q;
          penable_d = 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;

endmodule
